// File: rtl/pmt_cnt_buf_pkg.sv
// pmt_cnt_buf_pkg
//   Shared definitions for the PMT count buffer: acquisition state
//   encoding, default FIFO geometry and the exposure-count width.
package pmt_cnt_buf_pkg;

  localparam int unsigned DEF_DEPTH_LOG2 = 10;
  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned NUM_EXP_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACQ   = 2'd2,
    ST_DONE  = 2'd3
  } acq_state_e;

endpackage

// File: rtl/pmt_cnt_buf_if.sv
// pmt_cnt_buf_if
//   Bundles the count input, acquisition control and host read port of
//   pmt_cnt_buf.
//   slave  : the buffer side (counts/control/read request in, read data
//            and status out)
//   master : the upstream counter plus host side (mirror image)
//   Signals:
//     wPmtCnt_i / wCntValid_i   per-exposure count and its strobe
//     wNumExp_i / wArm_i        exposure count, sampled on the arm pulse
//     wAbort_i                  stop acquisition and flush the FIFO
//     wRdEn_i                   host read request
//     wRdData_o / wRdValid_o    read word, valid one cycle after request
//     wEmpty_o / wFull_o / wLevel_o   FIFO status
//     wOverflow_o / wBusy_o / wDone_o acquisition status
interface pmt_cnt_buf_if
  import pmt_cnt_buf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = DEF_WIDTH
);

  logic [WIDTH-1:0]     wPmtCnt_i;
  logic                 wCntValid_i;
  logic [NUM_EXP_W-1:0] wNumExp_i;
  logic                 wArm_i;
  logic                 wAbort_i;
  logic                 wRdEn_i;
  logic [WIDTH-1:0]     wRdData_o;
  logic                 wRdValid_o;
  logic                 wEmpty_o;
  logic                 wFull_o;
  logic [DEPTH_LOG2:0]  wLevel_o;
  logic                 wOverflow_o;
  logic                 wBusy_o;
  logic                 wDone_o;

  modport slave (
    input  wPmtCnt_i, wCntValid_i, wNumExp_i, wArm_i, wAbort_i, wRdEn_i,
    output wRdData_o, wRdValid_o, wEmpty_o, wFull_o, wLevel_o,
           wOverflow_o, wBusy_o, wDone_o
  );

  modport master (
    output wPmtCnt_i, wCntValid_i, wNumExp_i, wArm_i, wAbort_i, wRdEn_i,
    input  wRdData_o, wRdValid_o, wEmpty_o, wFull_o, wLevel_o,
           wOverflow_o, wBusy_o, wDone_o
  );

endinterface

// File: rtl/pmt_fifo_sync.sv
// pmt_fifo_sync
//   Single-clock FIFO of 2^DEPTH_LOG2 words with a synchronous-read RAM
//   (one cycle read latency) and DEPTH_LOG2+1 bit wrapping pointers.
//   Ports:
//     clk_i, rst_i        clock, asynchronous active-high reset
//     clr_i               flush: pointers to zero, read/write dropped
//     wr_en_i, wr_data_i  write request and word
//     wr_drop_o           write request refused because FIFO is full
//     rd_en_i             read request (ignored when empty)
//     rd_data_o           read word, held while rd_valid_o is low
//     rd_valid_o          rd_data_o updated this cycle
//     empty_o, full_o     status
//     level_o             words stored (wr_ptr - rd_ptr)
module pmt_fifo_sync
  import pmt_cnt_buf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  output logic                wr_drop_o,
  input  logic                rd_en_i,
  output logic [WIDTH-1:0]    rd_data_o,
  output logic                rd_valid_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [DEPTH_LOG2:0] level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    rd_data_q;
  logic                rd_valid_q;
  logic                rd_fire;
  logic                wr_fire;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (level_o == '0);
  // Level never exceeds DEPTH, so its MSB alone marks the full condition.
  assign full_o  = level_o[DEPTH_LOG2];

  assign rd_fire   = rd_en_i & ~empty_o & ~clr_i;
  // A same-cycle read frees the slot, so a write into a full FIFO still lands.
  assign wr_fire   = wr_en_i & ~clr_i & (~full_o | rd_fire);
  assign wr_drop_o = wr_en_i & ~clr_i & full_o & ~rd_fire;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(1);
    end
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_fire;
      // Read-before-write on a shared address returns the old (oldest) word.
      if (rd_fire) rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/pmt_cnt_buf.sv
// pmt_cnt_buf
//   Captures a programmed number of PMT exposure counts into a FIFO for
//   host readout. The first count after arming is discarded because it
//   covers only a partial exposure window.
//   Ports:
//     wHClk_i   sole clock, rising edge
//     wRst_i    asynchronous active-high reset
//     bus       pmt_cnt_buf_if.slave (count input, control, read port,
//               status)
module pmt_cnt_buf
  import pmt_cnt_buf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input logic         wHClk_i,
  input logic         wRst_i,
  pmt_cnt_buf_if.slave bus
);

  acq_state_e           state_q;
  logic [NUM_EXP_W-1:0] remain_q;
  logic                 ovf_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 fifo_wr_en;
  logic                 fifo_drop;

  assign fifo_wr_en = (state_q == ST_ACQ) & bus.wCntValid_i & ~bus.wAbort_i;

  pmt_fifo_sync #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (WIDTH)
  ) u_fifo (
    .clk_i     (wHClk_i),
    .rst_i     (wRst_i),
    .clr_i     (bus.wAbort_i),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i (bus.wPmtCnt_i),
    .wr_drop_o (fifo_drop),
    .rd_en_i   (bus.wRdEn_i),
    .rd_data_o (bus.wRdData_o),
    .rd_valid_o(bus.wRdValid_o),
    .empty_o   (bus.wEmpty_o),
    .full_o    (bus.wFull_o),
    .level_o   (bus.wLevel_o)
  );

  // busy/done are registered alongside the state so they change on the
  // same edge as the transition that causes them.
  always_ff @(posedge wHClk_i or posedge wRst_i) begin
    if (wRst_i) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.wAbort_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.wArm_i) begin
            state_q  <= ST_ARMED;
            remain_q <= bus.wNumExp_i;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (bus.wCntValid_i) begin
            if (remain_q == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_ACQ;
            end
          end
        end
        ST_ACQ: begin
          if (bus.wCntValid_i) begin
            remain_q <= remain_q - NUM_EXP_W'(1);
            if (fifo_drop) ovf_q <= 1'b1;
            if (remain_q == NUM_EXP_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wOverflow_o = ovf_q;
  assign bus.wDone_o     = done_q;
  assign bus.wBusy_o     = busy_q;

endmodule

// File: tb/tb_pmt_cnt_buf.sv
// tb_pmt_cnt_buf
//   Scoreboard bench for pmt_cnt_buf with a small FIFO (DEPTH_LOG2=2).
//   Directed acquisition scenarios followed by random traffic, checked
//   against a queue-based reference model of the acquisition rules.
module tb_pmt_cnt_buf;

  localparam int unsigned DL    = 2;
  localparam int unsigned W     = 16;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmt_cnt_buf_if #(.DEPTH_LOG2(DL), .WIDTH(W)) bus ();

  pmt_cnt_buf #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .wHClk_i(clk),
    .wRst_i (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle 1=armed 2=acquiring 3=done
  int             mphase = 0;
  int             mrem   = 0;
  bit             movf   = 1'b0;
  bit             mdone  = 1'b0;
  bit             mrdv   = 1'b0;
  logic [W-1:0]   mq[$];
  logic [W-1:0]   expq[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit v, input logic [W-1:0] c, input bit arm, input int ne,
                       input bit ab, input bit rd);
    mrdv = 1'b0;
    if (ab) begin
      mq.delete();
      mphase = 0;
      mdone  = 1'b0;
      return;
    end
    if (rd && mq.size() > 0) begin
      expq.push_back(mq.pop_front());
      mrdv = 1'b1;
    end
    case (mphase)
      0, 3: if (arm) begin
        mrem = ne; movf = 1'b0; mdone = 1'b0; mphase = 1;
      end
      1: if (v) begin
        if (mrem == 0) begin mphase = 3; mdone = 1'b1; end
        else mphase = 2;
      end
      2: if (v) begin
        mrem--;
        if (mq.size() < DEPTH) mq.push_back(c);
        else movf = 1'b1;
        if (mrem == 0) begin mphase = 3; mdone = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    mphase = 0; mrem = 0; movf = 1'b0; mdone = 1'b0; mrdv = 1'b0;
    mq.delete();
    expq.delete();
  endtask

  task automatic check_flags();
    chk("level", bus.wLevel_o, mq.size());
    chk("empty", bus.wEmpty_o, (mq.size() == 0));
    chk("full", bus.wFull_o, (mq.size() == DEPTH));
    chk("overflow", bus.wOverflow_o, movf);
    chk("done", bus.wDone_o, mdone);
    chk("busy", bus.wBusy_o, (mphase == 1 || mphase == 2));
    chk("rdvalid", bus.wRdValid_o, mrdv);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " level"}, bus.wLevel_o, 0);
    chk({tag, " empty"}, bus.wEmpty_o, 1);
    chk({tag, " full"}, bus.wFull_o, 0);
    chk({tag, " overflow"}, bus.wOverflow_o, 0);
    chk({tag, " done"}, bus.wDone_o, 0);
    chk({tag, " busy"}, bus.wBusy_o, 0);
    chk({tag, " rdvalid"}, bus.wRdValid_o, 0);
    chk({tag, " rddata"}, bus.wRdData_o, 0);
  endtask

  task automatic clear_inputs();
    bus.wPmtCnt_i = '0; bus.wCntValid_i = 1'b0; bus.wNumExp_i = '0;
    bus.wArm_i = 1'b0; bus.wAbort_i = 1'b0; bus.wRdEn_i = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, check status after the rising edge.
  task automatic step(input bit v, input logic [W-1:0] c, input bit arm, input int ne,
                      input bit ab, input bit rd);
    @(negedge clk);
    bus.wCntValid_i = v; bus.wPmtCnt_i = c; bus.wArm_i = arm;
    bus.wNumExp_i = 16'(ne); bus.wAbort_i = ab; bus.wRdEn_i = rd;
    model(v, c, arm, ne, ab, rd);
    @(posedge clk);
    #1;
    check_flags();
  endtask

  task automatic idle();         step(0, '0, 0, 0, 0, 0); endtask
  task automatic pulse(input logic [W-1:0] c); step(1, c, 0, 0, 0, 0); endtask
  task automatic arm(input int ne);  step(0, '0, 1, ne, 0, 0); endtask
  task automatic rd();           step(0, '0, 0, 0, 0, 1); endtask

  // Monitor: every presented read word is popped and compared.
  always @(posedge clk) begin
    #1;
    if (!rst && bus.wRdValid_o === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected rdvalid", 1, 0);
      end else begin
        chk("rddata", bus.wRdData_o, expq.pop_front());
      end
    end
  end

  initial begin
    clear_inputs();
    #1 rst = 1'b1;
    #2;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Three exposures, first pulse discarded.
    arm(3);
    pulse(9); pulse(10); pulse(11); pulse(12);
    chk("t039 level", bus.wLevel_o, 3);
    chk("t039 done", bus.wDone_o, 1);
    rd(); rd(); rd();
    idle();

    // Zero exposures: the discarded pulse ends the acquisition.
    arm(0);
    chk("t040 busy armed", bus.wBusy_o, 1);
    pulse(77);
    chk("t040 busy", bus.wBusy_o, 0);
    chk("t040 empty", bus.wEmpty_o, 1);
    chk("t040 done", bus.wDone_o, 1);

    // Overflow into a 4-word FIFO.
    arm(6);
    for (int i = 0; i < 7; i++) pulse(W'(100 + i));
    chk("t041 level", bus.wLevel_o, 4);
    chk("t041 overflow", bus.wOverflow_o, 1);
    chk("t041 done", bus.wDone_o, 1);

    // Full FIFO with simultaneous read and write.
    arm(3);
    pulse(1);
    step(1, 200, 0, 0, 0, 1);
    chk("t042 level", bus.wLevel_o, 4);
    chk("t042 overflow", bus.wOverflow_o, 0);

    // Abort in ACQ with two words stored.
    rd(); rd();
    chk("t043 level pre", bus.wLevel_o, 2);
    step(0, '0, 0, 0, 1, 1);
    chk("t043 empty", bus.wEmpty_o, 1);
    chk("t043 done", bus.wDone_o, 0);
    pulse(55);
    chk("t043 level post", bus.wLevel_o, 0);

    // Asynchronous reset mid-acquisition, then a normal acquisition.
    arm(5);
    pulse(0); pulse(1); pulse(2);
    #2;
    clear_inputs();
    rst = 1'b1;
    #1;
    check_reset("t044");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    arm(2);
    pulse(6); pulse(7); pulse(8);
    chk("t044 done", bus.wDone_o, 1);
    chk("t044 level", bus.wLevel_o, 2);
    rd(); rd();
    idle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 50), W'($urandom), ($urandom_range(0, 99) < 6),
           int'($urandom_range(0, 8)), ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 40));
    end
    clear_inputs();
    idle(); idle();
    chk("pending reads", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
